tx_flit_arbiter: RTL and testbench

TX_FLIT_ARBITER -- requirements
Module: tx_flit_arbiter

---
 rtl/tx_flit_arbiter_pkg.sv | 21 ++
 rtl/rr_pick_comb.sv | 28 ++
 rtl/tx_flit_arbiter.sv | 121 ++++++++++++
 tb/tb_tx_flit_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_flit_arbiter_pkg.sv
// Shared types for the TX flit arbiter: flit layout, channel-index helper and grant record.
package types;

  typedef struct packed {
    logic [3:0]  src;
    logic [11:0] payload;
  } flit_t;

  // Channel index width for up to 8 channels.
  localparam int CH_W_MAX = 3;

  function automatic int ch_w(input int n_ch);
    return $clog2(n_ch);
  endfunction

  typedef struct packed {
    logic [CH_W_MAX-1:0] index;
    logic                aged;
  } arb_grant_t;

endpackage

// File: rtl/rr_pick_comb.sv
// Round-robin picker: first requesting index at or after ptr, wrapping, as a one-hot grant.
module rr_pick_comb #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_flit_arbiter.sv
// Single-slot flit arbiter: aged channels, then channel 0, then round-robin over 1..N_CH-1.
// Define TX_ARB_AGING_EN to enable per-channel starvation counters and aged promotion.
module tx_flit_arbiter
  import types::*;
#(
  parameter int N_CH      = 3,
  parameter int AGE_LIMIT = 8,
  localparam int CH_W     = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  flit_t [N_CH-1:0]      in_flit,
  input  logic  [N_CH-1:0]      in_valid,
  output logic  [N_CH-1:0]      in_ready,
  output flit_t                 out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic  [CH_W-1:0]      out_ch,
  output logic                  aged_grant
);

  logic            can_load;
  logic            any_req;
  logic            load;
  logic [N_CH-1:0] rr_req;
  logic [N_CH-1:0] rr_grant;
  logic [N_CH-1:0] aged_vec;
  logic [N_CH-1:0] grant_vec;
  logic [CH_W-1:0] gnt_idx;
  arb_grant_t      gnt;

  logic [CH_W-1:0] rr_ptr_reg, rr_ptr_next;
  flit_t           out_flit_reg;
  logic [CH_W-1:0] out_ch_reg;
  logic            out_valid_reg;
  logic            aged_grant_reg;

  assign can_load = !out_valid_reg || out_ready;
  assign rr_req   = {in_valid[N_CH-1:1], 1'b0};

  rr_pick_comb #(.N(N_CH), .PTR_W(CH_W)) u_rr_pick (
    .req   (rr_req),
    .ptr   (rr_ptr_reg),
    .grant (rr_grant)
  );

  always_comb begin
    gnt = '0;
    if (|aged_vec) begin
      gnt.aged = 1'b1;
      for (int i = N_CH - 1; i >= 1; i--)
        if (aged_vec[i]) gnt.index = CH_W_MAX'(i);
    end else if (!in_valid[0]) begin
      for (int i = 1; i < N_CH; i++)
        if (rr_grant[i]) gnt.index = CH_W_MAX'(i);
    end
  end

  assign any_req   = in_valid[0] || (|rr_grant) || (|aged_vec);
  assign gnt_idx   = CH_W'(gnt.index);
  assign grant_vec = any_req ? (N_CH'(1) << gnt_idx) : '0;
  // Gate with rst_n as well so in_ready is quiet the instant reset asserts.
  assign in_ready  = (rst_n && can_load) ? grant_vec : '0;
  assign load      = |(in_ready & in_valid);

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (load && !gnt.aged && gnt_idx != '0)
      rr_ptr_next = (gnt_idx == CH_W'(N_CH - 1)) ? CH_W'(1) : CH_W'(gnt_idx + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg     <= CH_W'(1);
      out_flit_reg   <= '0;
      out_ch_reg     <= '0;
      out_valid_reg  <= 1'b0;
      aged_grant_reg <= 1'b0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      aged_grant_reg <= load && gnt.aged;
      if (load) begin
        out_flit_reg  <= in_flit[gnt_idx];
        out_ch_reg    <= gnt_idx;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef TX_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  assign aged_vec[0] = 1'b0;

  // Counters only advance when a load could happen, so stalls never age a channel.
  for (genvar gi = 1; gi < N_CH; gi++) begin : g_age
    logic [AGE_W-1:0] age_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        age_reg <= '0;
      else if (!in_valid[gi] || (load && grant_vec[gi]))
        age_reg <= '0;
      else if (can_load && age_reg != AGE_W'(AGE_LIMIT))
        age_reg <= age_reg + 1'b1;
    end

    assign aged_vec[gi] = in_valid[gi] && (age_reg == AGE_W'(AGE_LIMIT));
  end
`else
  assign aged_vec = '0;
`endif

  assign out_flit   = out_flit_reg;
  assign out_ch     = out_ch_reg;
  assign out_valid  = out_valid_reg;
  assign aged_grant = aged_grant_reg;

endmodule

// File: tb/tb_tx_flit_arbiter.sv
// Directed bench for tx_flit_arbiter (N_CH=4, AGE_LIMIT=3) with an expected-output queue.
module tb_tx_flit_arbiter;
  import types::*;

  localparam int N_CH      = 4;
  localparam int AGE_LIMIT = 3;
  localparam int CH_W      = $clog2(N_CH);

  typedef struct {
    logic [CH_W-1:0] ch;
    flit_t           flit;
    logic            aged;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  flit_t [N_CH-1:0]     in_flit;
  logic  [N_CH-1:0]     in_valid;
  logic  [N_CH-1:0]     in_ready;
  flit_t                out_flit;
  logic                 out_valid;
  logic                 out_ready;
  logic  [CH_W-1:0]     out_ch;
  logic                 aged_grant;

  exp_t exp_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   tag;
  bit   aging_on;

  tx_flit_arbiter #(.N_CH(N_CH), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .aged_grant (aged_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    assert_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic flit_t mk_flit(input int ch, input int t);
    flit_t f;
    f.src     = 4'(ch);
    f.payload = 12'(t);
    return f;
  endfunction

  task automatic set_flits(input int t);
    for (int i = 0; i < N_CH; i++) in_flit[i] = mk_flit(i, t);
  endtask

  task automatic push(input int ch, input int t, input logic aged);
    exp_t e;
    e.ch   = CH_W'(ch);
    e.flit = mk_flit(ch, t);
    e.aged = aged;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Output monitor: every accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      assert_cnt++;
      assert (exp_q.size() != 0) else begin
        fail_cnt++;
        $error("FAIL unexpected_output observed=ch%0d expected=none", out_ch);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("out_flit", 32'(out_flit), 32'(e.flit));
        check("aged_grant", 32'(aged_grant), 32'(e.aged));
        $display("out: ch=%0d flit=%04h aged=%0b", out_ch, out_flit, aged_grant);
      end
    end
  end

  initial begin
`ifdef TX_ARB_AGING_EN
    aging_on = 1'b1;
`else
    aging_on = 1'b0;
`endif
    // Reset with all channels valid and downstream ready.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = '1;
    tag       = 1;
    set_flits(tag);
    repeat (2) @(posedge clk);
    sample();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_flit", 32'(out_flit), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_aged_grant", 32'(aged_grant), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    check("first_in_ready_ch0", 32'(in_ready), 32'b0001);
    check("first_out_valid_low", 32'(out_valid), 0);
    push(0, tag, 1'b0);
    step();
    in_valid = '0;
    sample();
    check("first_out_valid_high", 32'(out_valid), 1);
    check("idle_in_ready", 32'(in_ready), 0);
    step();
    sample();
    check("drain_clears_valid", 32'(out_valid), 0);

    // Round-robin over channels 1..3 with channel 0 idle.
    step();
    tag = 2;
    set_flits(tag);
    in_valid = 4'b1110;
    for (int k = 0; k < 6; k++) push((k % 3) + 1, tag, 1'b0);
    repeat (6) step();
    in_valid = '0;
    step();
    step();
    check("rr_queue_empty", 32'(exp_q.size()), 0);

    // Stall: register full, out_ready low for 5 cycles.
    out_ready = 1'b0;
    tag = 3;
    set_flits(tag);
    in_valid = 4'b1110;
    push(1, tag, 1'b0);
    step();
    sample();
    check("stall_loaded_valid", 32'(out_valid), 1);
    check("stall_loaded_ch", 32'(out_ch), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      sample();
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_flit", 32'(out_flit), 32'(mk_flit(1, tag)));
      check("stall_out_ch", 32'(out_ch), 1);
    end
    step();
    out_ready = 1'b1;
    push(2, tag, 1'b0);
    sample();
    check("release_in_ready_ch2", 32'(in_ready), 32'b0100);
    step();
    in_valid = '0;
    sample();
    check("release_same_cycle_valid", 32'(out_valid), 1);
    check("release_same_cycle_ch", 32'(out_ch), 2);
    step();
    step();
    check("stall_queue_empty", 32'(exp_q.size()), 0);

    // Channel 0 and channel 2 always valid: aging decides whether channel 2 ever wins.
    tag = 4;
    set_flits(tag);
    in_valid = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      if (aging_on && (k % 4) == 3) push(2, tag, 1'b1);
      else push(0, tag, 1'b0);
    end
    repeat (8) step();
    in_valid = '0;
    step();
    step();
    check("age_queue_empty", 32'(exp_q.size()), 0);

    // Reset asserted mid-cycle with a flit stuck in the output register.
    out_ready = 1'b0;
    tag = 5;
    set_flits(tag);
    in_valid = 4'b0010;
    step();
    in_valid = '1;
    sample();
    check("pre_reset_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_flit", 32'(out_flit), 0);
    check("async_rst_out_ch", 32'(out_ch), 0);
    check("async_rst_in_ready", 32'(in_ready), 0);
    step();
    in_valid  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    repeat (3) step();
    sample();
    check("no_stale_flit", 32'(out_valid), 0);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
